// File: rtl/cmd_dispatch.sv
// Command-byte dispatcher: buffers one parser byte and broadcasts it to NCONS consumers.
// Optional stuck-consumer timeout/drop enabled by defining DISPATCH_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no byte held; a nonzero cmd_mask is latched at once
// S_OFFER | held byte offered to targeted consumers that have not yet accepted
module cmd_dispatch #(
   parameter int NCONS   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       cmd_mask,
   input  logic [7:0]       data,
   output logic             data_ack,
   output logic [7:0]       cons_data,
   output logic             cons_sof,
   output logic [NCONS-1:0] cons_valid,
   input  logic [NCONS-1:0] cons_ready,
   output logic             busy,
   output logic [NCONS-1:0] err_mask
);

   typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [7:0]       hold_data;
   logic [NCONS-1:0] pend, done, done_nxt;
   logic [NCONS-1:0] em, acc;
   logic             in_frame, in_frame_nxt, sof_r;
   logic             complete, drop, release_byte, load;
   logic             mask_unused;

   // Bits of cmd_mask at NCONS and above only matter for the "byte presented" test.
   assign mask_unused = ^cmd_mask;

   always_comb begin
      em           = cmd_mask[NCONS-1:0];
      cons_valid   = '0;
      acc          = '0;
      complete     = 1'b0;
      state_nxt    = state;
      in_frame_nxt = in_frame;
      if (state == S_OFFER) begin
         cons_valid = pend & ~done;
         acc        = cons_valid & cons_ready;
         complete   = ((done | acc) == pend);
      end
      release_byte = complete | drop;
      // Reset gating keeps a byte from being popped and then discarded by the reset.
      load     = !reset && (cmd_mask != 8'd0) && ((state == S_IDLE) || release_byte);
      data_ack = load;
      done_nxt = done | acc;
      if (load) begin
         state_nxt    = (em != '0) ? S_OFFER : S_IDLE;
         in_frame_nxt = 1'b1;
         done_nxt     = '0;
      end else if ((state == S_IDLE) || release_byte) begin
         state_nxt    = S_IDLE;
         in_frame_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         hold_data <= 8'd0;
         pend      <= '0;
         done      <= '0;
         in_frame  <= 1'b0;
         sof_r     <= 1'b0;
      end else begin
         state    <= state_nxt;
         done     <= done_nxt;
         in_frame <= in_frame_nxt;
         if (load) begin
            hold_data <= data;
            pend      <= em;
            sof_r     <= ~in_frame;
         end
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   logic [7:0]       tmo;
   logic [NCONS-1:0] err_r;

   assign drop = (state == S_OFFER) && !complete && (tmo == 8'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo   <= 8'd0;
         err_r <= '0;
      end else begin
         if (load)
            tmo <= 8'(TIMEOUT);
         else if ((state == S_OFFER) && !complete && (tmo != 8'd0))
            tmo <= tmo - 8'd1;
         // Consumers accepting in the drop cycle are not blamed.
         if (drop)
            err_r <= err_r | (pend & ~done & ~cons_ready);
      end
   end

   assign err_mask = err_r;
`else
   assign drop     = 1'b0;
   assign err_mask = '0;
`endif

   assign busy      = (state == S_OFFER);
   assign cons_data = hold_data;
   assign cons_sof  = sof_r;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed vector table, corner sequences and a
// randomized run against a per-consumer delivery model (DISPATCH_TIMEOUT_EN aware).
module tb_cmd_dispatch;

   localparam int TMO = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cmd_mask = 8'd0, data = 8'd0, cons_ready = 8'd0;
   logic       data_ack, cons_sof, busy;
   logic [7:0] cons_data, cons_valid, err_mask;

   logic [7:0] cmd_mask4 = 8'd0, data4 = 8'd0;
   logic [3:0] cons_ready4 = 4'hF;
   logic       data_ack4, cons_sof4, busy4;
   logic [7:0] cons_data4;
   logic [3:0] cons_valid4, err_mask4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cmd_dispatch #(.NCONS(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .cmd_mask(cmd_mask), .data(data), .data_ack(data_ack),
      .cons_data(cons_data), .cons_sof(cons_sof), .cons_valid(cons_valid),
      .cons_ready(cons_ready), .busy(busy), .err_mask(err_mask));

   cmd_dispatch #(.NCONS(4), .TIMEOUT(TMO)) dut4 (
      .clk(clk), .reset(reset), .cmd_mask(cmd_mask4), .data(data4), .data_ack(data_ack4),
      .cons_data(cons_data4), .cons_sof(cons_sof4), .cons_valid(cons_valid4),
      .cons_ready(cons_ready4), .busy(busy4), .err_mask(err_mask4));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after posedge, return at the following negedge.
   task automatic cyc(input logic r, input logic [7:0] m, input logic [7:0] d,
                      input logic [7:0] rdy, input logic [7:0] m4, input logic [7:0] d4);
      @(posedge clk);
      #1;
      reset = r; cmd_mask = m; data = d; cons_ready = rdy;
      cmd_mask4 = m4; data4 = d4;
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rst_ack", data_ack, 0);
      chk("rst_valid", cons_valid, 0);
      chk("rst_data", cons_data, 0);
      chk("rst_sof", cons_sof, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_mask, 0);
      chk("rst_valid4", cons_valid4, 0);
   endtask

   // Reference model: each consumer has an outstanding-delivery slot holding the byte
   // it still owes an accept for; a new byte can be taken only when nobody owes.
   typedef struct packed { logic [7:0] d; logic s; } ent_t;
   logic       m_has [8];
   ent_t       m_ent [8];
   logic       m_in_frame;
   logic [7:0] m_err;
   int         m_age;

   task automatic m_clear();
      for (int i = 0; i < 8; i++) begin m_has[i] = 1'b0; m_ent[i] = '0; end
      m_in_frame = 1'b0;
      m_err = 8'd0;
      m_age = 0;
   endtask

   task automatic model_step(output logic ack_exp);
      logic [7:0] owe, rem;
      bit         first;
      owe = 8'd0;
      for (int i = 0; i < 8; i++) owe[i] = m_has[i];
      chk("rnd_valid", cons_valid, owe);
      chk("rnd_busy", busy, (owe != 0));
      chk("rnd_err", err_mask, m_err);
      first = 1'b1;
      for (int i = 0; i < 8; i++)
         if (m_has[i] && first) begin
            first = 1'b0;
            chk("rnd_data", cons_data, m_ent[i].d);
            chk("rnd_sof", cons_sof, m_ent[i].s);
         end
      for (int i = 0; i < 8; i++) if (owe[i] && cons_ready[i]) m_has[i] = 1'b0;
      rem = 8'd0;
      for (int i = 0; i < 8; i++) rem[i] = m_has[i];
`ifdef DISPATCH_TIMEOUT_EN
      if (owe != 0) begin
         m_age++;
         if (rem != 0 && m_age == TMO + 1) begin
            m_err = m_err | rem;
            for (int i = 0; i < 8; i++) m_has[i] = 1'b0;
            rem = 8'd0;
         end
      end
`endif
      ack_exp = (rem == 0) && (cmd_mask != 0);
      chk("rnd_ack", data_ack, ack_exp);
      if (ack_exp) begin
         for (int i = 0; i < 8; i++)
            if (cmd_mask[i]) begin m_has[i] = 1'b1; m_ent[i] = '{d: data, s: !m_in_frame}; end
         m_in_frame = 1'b1;
         m_age = 0;
      end else if (rem == 0 && cmd_mask == 0) begin
         m_in_frame = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] m, d, rdy;
      logic       ack;
      logic [7:0] vld, cd;
      logic       sof, bsy;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic       a;
      int         frm_left, gap_left;
      logic [7:0] pm, pd, stuck, rdy;

      // single byte, then a staggered-ready 3-byte frame
      tbl[0]  = '{8'h05, 8'h3C, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h05, 8'h3C, 1'b1, 1'b1};
      tbl[2]  = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0};
      tbl[3]  = '{8'h03, 8'hA1, 8'h01, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0};
      tbl[4]  = '{8'h03, 8'hA2, 8'h01, 1'b0, 8'h03, 8'hA1, 1'b1, 1'b1};
      tbl[5]  = '{8'h03, 8'hA2, 8'h01, 1'b0, 8'h02, 8'hA1, 1'b1, 1'b1};
      tbl[6]  = '{8'h03, 8'hA2, 8'h01, 1'b0, 8'h02, 8'hA1, 1'b1, 1'b1};
      tbl[7]  = '{8'h03, 8'hA2, 8'h01, 1'b0, 8'h02, 8'hA1, 1'b1, 1'b1};
      tbl[8]  = '{8'h03, 8'hA2, 8'h03, 1'b1, 8'h02, 8'hA1, 1'b1, 1'b1};
      tbl[9]  = '{8'h03, 8'hA3, 8'h03, 1'b1, 8'h03, 8'hA2, 1'b0, 1'b1};
      tbl[10] = '{8'h00, 8'h00, 8'h03, 1'b0, 8'h03, 8'hA3, 1'b0, 1'b1};
      tbl[11] = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 8'hA3, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, tbl[i].m, tbl[i].d, tbl[i].rdy, 8'h00, 8'h00);
         chk($sformatf("vec%0d_ack", i), data_ack, tbl[i].ack);
         chk($sformatf("vec%0d_valid", i), cons_valid, tbl[i].vld);
         chk($sformatf("vec%0d_data", i), cons_data, tbl[i].cd);
         chk($sformatf("vec%0d_sof", i), cons_sof, tbl[i].sof);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      end

      // back-to-back streaming, 16 bytes
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 8'hFF, 8'(8'h80 + k), 8'hFF, 8'h00, 8'h00);
         chk("strm_ack", data_ack, 1);
         if (k > 0) begin
            chk("strm_valid", cons_valid, 8'hFF);
            chk("strm_data", cons_data, 8'(8'h80 + k - 1));
            chk("strm_sof", cons_sof, (k == 1));
         end else begin
            chk("strm_valid0", cons_valid, 8'h00);
         end
      end
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("strm_last_data", cons_data, 8'h8F);
      chk("strm_last_ack", data_ack, 0);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("strm_idle", busy, 0);

      // out-of-range mask on the 4-consumer instance
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'h55);
      chk("oor_ack", data_ack4, 1);
      chk("oor_valid", cons_valid4, 0);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("oor_valid_b", cons_valid4, 0);
      chk("oor_busy", busy4, 0);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h66);
      chk("oor_ack2", data_ack4, 1);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("oor_valid2", cons_valid4, 4'h1);
      chk("oor_data2", cons_data4, 8'h66);
      chk("oor_sof2", cons_sof4, 1);

      // reset while byte 2 of a 5-byte frame is being offered
      do_reset();
      cyc(1'b0, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00);
      chk("rmf_ack0", data_ack, 1);
      cyc(1'b0, 8'h01, 8'h11, 8'h01, 8'h00, 8'h00);
      chk("rmf_ack1", data_ack, 1);
      chk("rmf_sof0", cons_sof, 1);
      cyc(1'b0, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00);
      chk("rmf_hold_data", cons_data, 8'h11);
      chk("rmf_hold_ack", data_ack, 0);
      cyc(1'b1, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00);
      chk("rmf_rst_ack", data_ack, 0);
      cyc(1'b0, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00);
      chk("rmf_post_valid", cons_valid, 0);
      chk("rmf_post_data", cons_data, 0);
      chk("rmf_post_sof", cons_sof, 0);
      chk("rmf_post_busy", busy, 0);
      chk("rmf_post_ack", data_ack, 1);
      cyc(1'b0, 8'h01, 8'h13, 8'h01, 8'h00, 8'h00);
      chk("rmf_next_data", cons_data, 8'h12);
      chk("rmf_next_sof", cons_sof, 1);
      cyc(1'b0, 8'h01, 8'h14, 8'h01, 8'h00, 8'h00);
      chk("rmf_b3_sof", cons_sof, 0);
      cyc(1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
      chk("rmf_b4_data", cons_data, 8'h14);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);

      // stuck consumer 2
      do_reset();
      cyc(1'b0, 8'h06, 8'h77, 8'h02, 8'h00, 8'h00);
      chk("tmo_load", data_ack, 1);
`ifdef DISPATCH_TIMEOUT_EN
      for (int k = 1; k <= TMO; k++) begin
         cyc(1'b0, 8'h01, 8'h78, 8'h02, 8'h00, 8'h00);
         chk("tmo_wait_ack", data_ack, 0);
         chk("tmo_wait_valid", cons_valid, (k == 1) ? 8'h06 : 8'h04);
      end
      cyc(1'b0, 8'h01, 8'h78, 8'h02, 8'h00, 8'h00);
      chk("tmo_drop_ack", data_ack, 1);
      chk("tmo_drop_err", err_mask, 8'h00);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("tmo_next_valid", cons_valid, 8'h01);
      chk("tmo_next_data", cons_data, 8'h78);
      chk("tmo_err", err_mask, 8'h04);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("tmo_err_sticky", err_mask, 8'h04);
      chk("tmo_idle", busy, 0);
`else
      for (int k = 1; k <= TMO + 4; k++) begin
         cyc(1'b0, 8'h01, 8'h78, 8'h02, 8'h00, 8'h00);
         chk("wait_ack", data_ack, 0);
         chk("wait_valid", cons_valid, (k == 1) ? 8'h06 : 8'h04);
         chk("wait_err", err_mask, 0);
      end
      cyc(1'b0, 8'h01, 8'h78, 8'h04, 8'h00, 8'h00);
      chk("wait_release_ack", data_ack, 1);
      cyc(1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      chk("wait_next_data", cons_data, 8'h78);
      chk("wait_next_valid", cons_valid, 8'h01);
`endif

      // randomized frames against the reference model
      do_reset();
      m_clear();
      frm_left = 0; gap_left = 0; pm = 8'd0; pd = 8'd0; stuck = 8'd0;
      for (int c = 0; c < 3000; c++) begin
         if (frm_left == 0 && gap_left == 0) begin
            frm_left = $urandom_range(1, 5);
            pm = 8'($urandom_range(1, 255));
            pd = 8'($urandom);
         end
`ifdef DISPATCH_TIMEOUT_EN
         if (c % 64 == 0)
            stuck = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
`endif
         rdy = 8'($urandom) & ~stuck;
         if (frm_left > 0) cyc(1'b0, pm, pd, rdy, 8'h00, 8'h00);
         else              cyc(1'b0, 8'h00, 8'($urandom), rdy, 8'h00, 8'h00);
         model_step(a);
         if (frm_left == 0) gap_left--;
         else if (a) begin
            frm_left--;
            pm = 8'($urandom_range(1, 255));
            pd = 8'($urandom);
            if (frm_left == 0) gap_left = $urandom_range(1, 3);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
